button_debounce_ctrl: RTL and testbench

- Control stage directly upstream of the processor's debounce counter; wraps the counter into a complete debouncer for one ATM front-panel button or coin sensor.
- Synchronises the raw input and starts the shared debounce counter on every apparent input change.
- Commits a new clean level only when the counter reports its settle interval with the input still at the new level.
- Produces the clean level, single-cycle press/release pulses and a saturating press count for the processor.

---
 rtl/button_debounce_ctrl_if.sv | 36 +++
 rtl/button_debounce_ctrl.sv | 137 +++++++++++++
 tb/tb_button_debounce_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_ctrl_if.sv
// Processor-facing signal bundle for the button debouncer control stage.
// The slave side is the debouncer; the master side is the environment (sensor, counter, processor).
interface button_debounce_ctrl_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   button_raw;
  logic                   counter_done;
  logic                   count_clear;
  logic                   counter_reset;
  logic                   button_level;
  logic                   press_pulse;
  logic                   release_pulse;
  logic [COUNT_WIDTH-1:0] press_count;

  modport master (
    output button_raw,
    output counter_done,
    output count_clear,
    input  counter_reset,
    input  button_level,
    input  press_pulse,
    input  release_pulse,
    input  press_count
  );

  modport slave (
    input  button_raw,
    input  counter_done,
    input  count_clear,
    output counter_reset,
    output button_level,
    output press_pulse,
    output release_pulse,
    output press_count
  );
endinterface

// File: rtl/button_debounce_ctrl.sv
// Debounce control for one front-panel button or coin sensor: synchronises the raw level,
// drives an external settle counter and commits a clean level with press/release pulses.
module button_debounce_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  button_debounce_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    WAIT_LOW    = 2'b10
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_in_s;
  state_t                 state_r;
  state_t                 next_state_s;
  logic                   press_commit_s;
  logic                   release_commit_s;
  logic                   waiting_next_s;
  logic                   counter_reset_r;
  logic                   button_level_r;
  logic                   press_pulse_r;
  logic                   release_pulse_r;
  logic [COUNT_WIDTH-1:0] press_count_r;

  // Input synchroniser chain for the asynchronous raw level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.button_raw};
    end
  end

  assign sync_in_s = sync_r[SYNC_STAGES-1];

  // Debounce state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= STABLE_LOW;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a reverted input outranks counter_done so a bounce never commits.
  always_comb begin
    next_state_s     = state_r;
    press_commit_s   = 1'b0;
    release_commit_s = 1'b0;
    case (state_r)
      STABLE_LOW: begin
        if (sync_in_s) next_state_s = WAIT_HIGH;
        else           next_state_s = STABLE_LOW;
      end
      WAIT_HIGH: begin
        if (!sync_in_s) begin
          next_state_s = STABLE_LOW;
        end else if (bus.counter_done) begin
          next_state_s   = STABLE_HIGH;
          press_commit_s = 1'b1;
        end else begin
          next_state_s = WAIT_HIGH;
        end
      end
      STABLE_HIGH: begin
        if (!sync_in_s) next_state_s = WAIT_LOW;
        else            next_state_s = STABLE_HIGH;
      end
      WAIT_LOW: begin
        if (sync_in_s) begin
          next_state_s = STABLE_HIGH;
        end else if (bus.counter_done) begin
          next_state_s     = STABLE_LOW;
          release_commit_s = 1'b1;
        end else begin
          next_state_s = WAIT_LOW;
        end
      end
      default: begin
        next_state_s = STABLE_LOW;
      end
    endcase
  end

  assign waiting_next_s = (next_state_s == WAIT_HIGH) || (next_state_s == WAIT_LOW);

  // Registered counter control, clean level and one-cycle commit pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_reset_r <= 1'b1;
      button_level_r  <= 1'b0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
    end else begin
      counter_reset_r <= !waiting_next_s;
      press_pulse_r   <= press_commit_s;
      release_pulse_r <= release_commit_s;
      if (press_commit_s) begin
        button_level_r <= 1'b1;
      end else if (release_commit_s) begin
        button_level_r <= 1'b0;
      end else begin
        button_level_r <= button_level_r;
      end
    end
  end

  // Saturating press counter; a clear in the same cycle as a press leaves it at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_count_r <= '0;
    end else if (bus.count_clear) begin
      press_count_r <= '0;
    end else if (press_commit_s && (press_count_r != COUNT_MAX)) begin
      press_count_r <= press_count_r + COUNT_ONE;
    end else begin
      press_count_r <= press_count_r;
    end
  end

  assign bus.counter_reset = counter_reset_r;
  assign bus.button_level  = button_level_r;
  assign bus.press_pulse   = press_pulse_r;
  assign bus.release_pulse = release_pulse_r;
  assign bus.press_count   = press_count_r;

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Self-checking bench: run-length reference model of the debouncer plus a settle counter model.
module tb_button_debounce_ctrl;

  localparam int SS   = 2;
  localparam int CW   = 2;
  localparam int TERM = 20;
  localparam int MAXC = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  button_debounce_ctrl_if #(.COUNT_WIDTH(CW)) bus();

  button_debounce_ctrl #(.SYNC_STAGES(SS), .COUNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Debounce counter the DUT controls: counts up to TERM and holds while released.
  int cnt;
  always @(posedge clock or posedge reset) begin
    if (reset)                  cnt <= 0;
    else if (bus.counter_reset) cnt <= 0;
    else if (cnt != TERM)       cnt <= cnt + 1;
  end
  assign bus.counter_done = (cnt == TERM);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: a new level commits once sync_in has differed from the committed level
  // for TERM+2 consecutive edges (one edge to start waiting, TERM counts, one to commit).
  bit hist [SS];
  bit m_level, m_press, m_release, m_crst;
  int m_run, m_count;
  int press_seen = 0;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int i = 0; i < SS; i++) hist[i] = 1'b0;
        m_level = 1'b0; m_run = 0; m_count = 0; m_crst = 1'b1;
        m_press = 1'b0; m_release = 1'b0;
      end else begin
        bit s;
        s = hist[0];
        for (int i = 0; i < SS - 1; i++) hist[i] = hist[i+1];
        hist[SS-1] = bus.button_raw;
        m_press = 1'b0; m_release = 1'b0;
        if (s != m_level) begin
          m_run++;
          if (m_run == TERM + 2) begin
            m_level = s; m_press = s; m_release = !s; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
        m_crst = (m_run == 0);
        if (bus.count_clear)                   m_count = 0;
        else if (m_press && m_count != MAXC)   m_count++;
      end
      #1;
      check("counter_reset", 32'(bus.counter_reset), 32'(m_crst));
      check("button_level",  32'(bus.button_level),  32'(m_level));
      check("press_pulse",   32'(bus.press_pulse),   32'(m_press));
      check("release_pulse", 32'(bus.release_pulse), 32'(m_release));
      check("press_count",   32'(bus.press_count),   32'(m_count));
      if (bus.press_pulse === 1'b1) press_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_press(input bit clr_on_commit);
    bus.button_raw = 1'b1;
    tick(23);
    bus.count_clear = clr_on_commit;
    tick(1);
    bus.count_clear = 1'b0;
  endtask

  task automatic do_release();
    bus.button_raw = 1'b0;
    tick(26);
  endtask

  int p0;
  int hold;
  int exp_cnt [5] = '{1, 2, 3, 3, 3};

  initial begin
    bus.button_raw  = 1'b0;
    bus.count_clear = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_counter_reset", 32'(bus.counter_reset), 32'd1);
    check("reset_level",         32'(bus.button_level),  32'd0);
    check("reset_press_count",   32'(bus.press_count),   32'd0);
    check("reset_pulses", 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(5);

    // Bounce from low: 1,0,1,0 with 5-cycle periods then hold 0.
    p0 = press_seen;
    for (int i = 0; i < 4; i++) begin
      bus.button_raw = (i % 2 == 0);
      tick(5);
    end
    bus.button_raw = 1'b0;
    tick(30);
    check("bounce_no_press", 32'(press_seen - p0),    32'd0);
    check("bounce_level",    32'(bus.button_level),   32'd0);
    check("bounce_count",    32'(bus.press_count),    32'd0);

    // Clean press with literal timing.
    bus.button_raw = 1'b1;
    tick(2);
    check("press_crst_held", 32'(bus.counter_reset), 32'd1);
    tick(1);
    check("press_crst_fall", 32'(bus.counter_reset), 32'd0);
    tick(20);
    check("press_not_early", 32'(bus.press_pulse),  32'd0);
    check("level_not_early", 32'(bus.button_level), 32'd0);
    tick(1);
    check("press_pulse_lit", 32'(bus.press_pulse),   32'd1);
    check("press_level_lit", 32'(bus.button_level),  32'd1);
    check("press_count_lit", 32'(bus.press_count),   32'd1);
    check("press_crst_rise", 32'(bus.counter_reset), 32'd1);
    tick(1);
    check("press_pulse_end", 32'(bus.press_pulse),   32'd0);

    // Clean release.
    bus.button_raw = 1'b0;
    tick(24);
    check("release_pulse_lit", 32'(bus.release_pulse), 32'd1);
    check("release_level_lit", 32'(bus.button_level),  32'd0);
    check("release_count_lit", 32'(bus.press_count),   32'd1);
    tick(1);
    check("release_pulse_end", 32'(bus.release_pulse), 32'd0);
    tick(5);

    // Input reverts in the very cycle counter_done is seen in WAIT_HIGH.
    bus.button_raw = 1'b1;
    tick(21);
    bus.button_raw = 1'b0;
    tick(2);
    check("conflict_done_high", 32'(bus.counter_done), 32'd1);
    tick(1);
    check("conflict_no_press", 32'(bus.press_pulse),   32'd0);
    check("conflict_level",    32'(bus.button_level),  32'd0);
    check("conflict_crst",     32'(bus.counter_reset), 32'd1);
    tick(5);

    // Saturation and clear.
    bus.count_clear = 1'b1;
    tick(1);
    bus.count_clear = 1'b0;
    check("clear_count", 32'(bus.press_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_press(1'b0);
      check("sat_count", 32'(bus.press_count), 32'(exp_cnt[i]));
      do_release();
    end
    do_press(1'b1);
    check("clear_wins_pulse", 32'(bus.press_pulse), 32'd1);
    check("clear_wins_count", 32'(bus.press_count), 32'd0);
    do_release();

    // Reset asserted mid WAIT_HIGH, input held high through release.
    bus.button_raw = 1'b1;
    tick(10);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_crst",   32'(bus.counter_reset), 32'd1);
    check("rst_mid_level",  32'(bus.button_level),  32'd0);
    check("rst_mid_pulses", 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
    p0 = press_seen;
    tick(2);
    reset = 1'b0;
    tick(23);
    check("rst_rel_level_early", 32'(bus.button_level), 32'd0);
    tick(1);
    check("rst_rel_press", 32'(bus.press_pulse),  32'd1);
    check("rst_rel_level", 32'(bus.button_level), 32'd1);
    tick(5);
    check("rst_rel_one_press", 32'(press_seen - p0), 32'd1);
    do_release();

    // Randomised bouncing and holds against the reference model.
    repeat (300) begin
      bus.button_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) hold = $urandom_range(22, 35);
      else                           hold = $urandom_range(1, 12);
      if ($urandom_range(0, 19) == 0) bus.count_clear = 1'b1;
      tick(1);
      bus.count_clear = 1'b0;
      if (hold > 1) tick(hold - 1);
    end
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
